// File: rtl/rlbp_pkg.sv
// rtl/rlbp_pkg.sv - shared types, defaults and helpers for the RLBP phase generator
package rlbp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int NCH_DEF = 7;
    localparam int CW_DEF  = 12;

    // A programmed period of 0 stands for the full 2^w count range.
    function automatic logic [32:0] eff_period(input logic [31:0] p, input int unsigned w);
        if (p == 32'd0) begin
            return 33'd1 << w;
        end
        return {1'b0, p};
    endfunction

endpackage

// File: rtl/rlbp_phase_chan.sv
// rtl/rlbp_phase_chan.sv - one output channel: shadowed window config, comparator, output flop
module rlbp_phase_chan
    import rlbp_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          run,
    input  logic [CW-1:0] cnt,
    input  logic [CW-1:0] rise_in,
    input  logic [CW-1:0] fall_in,
    input  logic          pol_in,
    input  logic          en_in,
    output logic          out
);

    logic [CW-1:0] rise_q, rise_d;
    logic [CW-1:0] fall_q, fall_d;
    logic          pol_q, pol_d;
    logic          en_q, en_d;
    logic          out_q, out_d;
    logic          active;

    always_comb begin
        rise_d = rise_q;
        fall_d = fall_q;
        pol_d  = pol_q;
        en_d   = en_q;
        if (load) begin
            rise_d = rise_in;
            fall_d = fall_in;
            pol_d  = pol_in;
            en_d   = en_in;
        end
    end

    // Rise above fall describes a window that wraps through the frame boundary.
    always_comb begin
        active = 1'b0;
        if (rise_q < fall_q) begin
            active = (cnt >= rise_q) && (cnt < fall_q);
        end else if (rise_q > fall_q) begin
            active = (cnt >= rise_q) || (cnt < fall_q);
        end
    end

    always_comb begin
        out_d = pol_in;
        if (run) begin
            out_d = (active & en_q) ^ pol_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rise_q <= '0;
            fall_q <= '0;
            pol_q  <= 1'b0;
            en_q   <= 1'b0;
            out_q  <= pol_in;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
            pol_q  <= pol_d;
            en_q   <= en_d;
            out_q  <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/rlbp_phase_gen.sv
// rtl/rlbp_phase_gen.sv - multi-channel frame phase generator; RLBP_BURST_EN adds burst_len/frame_idx
module rlbp_phase_gen
    import rlbp_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              oneshot,
    input  logic [CW-1:0]     period,
    input  logic [NCH*CW-1:0] t_rise,
    input  logic [NCH*CW-1:0] t_fall,
    input  logic [NCH-1:0]    polarity,
    input  logic [NCH-1:0]    chan_en,
    output logic [NCH-1:0]    out,
    output logic [CW-1:0]     count,
    output logic              busy,
    output logic              frame_done
`ifdef RLBP_BURST_EN
    ,
    input  logic [15:0]       burst_len,
    output logic [15:0]       frame_idx
`endif
);

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] period_q, period_d;
    logic          oneshot_q, oneshot_d;
    logic          stop_pend_q, stop_pend_d;
    logic          frame_done_q, frame_done_d;
    logic          load;
    logic          is_last;
    logic          burst_done;
    logic [CW:0]   eff_per;
    logic [CW:0]   cnt_inc;

    assign eff_per = (CW+1)'(eff_period(32'(period_q), CW));
    assign cnt_inc = {1'b0, count_q} + {{CW{1'b0}}, 1'b1};
    assign is_last = (cnt_inc == eff_per);

`ifdef RLBP_BURST_EN
    logic [15:0] burst_len_q, burst_len_d;
    logic [15:0] frame_idx_q, frame_idx_d;

    assign burst_done = (burst_len_q != 16'd0) &&
                        (({1'b0, frame_idx_q} + 17'd1) >= {1'b0, burst_len_q});

    always_comb begin
        burst_len_d = burst_len_q;
        frame_idx_d = frame_idx_q;
        if (state_q == IDLE) begin
            if (start && !stop) begin
                burst_len_d = burst_len;
                frame_idx_d = 16'd0;
            end
        end else if (is_last && (frame_idx_q != 16'hFFFF)) begin
            frame_idx_d = frame_idx_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            burst_len_q <= 16'd0;
            frame_idx_q <= 16'd0;
        end else begin
            burst_len_q <= burst_len_d;
            frame_idx_q <= frame_idx_d;
        end
    end

    assign frame_idx = frame_idx_q;
`else
    assign burst_done = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        period_d     = period_q;
        oneshot_d    = oneshot_q;
        stop_pend_d  = stop_pend_q;
        frame_done_d = 1'b0;
        load         = 1'b0;
        case (state_q)
            IDLE: begin
                count_d     = '0;
                stop_pend_d = 1'b0;
                if (start && !stop) begin
                    state_d   = RUN;
                    load      = 1'b1;
                    period_d  = period;
                    oneshot_d = oneshot;
                end
            end
            RUN: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (is_last) begin
                    count_d      = '0;
                    frame_done_d = 1'b1;
                    if (oneshot_q || stop_pend_q || stop || burst_done) begin
                        state_d     = IDLE;
                        stop_pend_d = 1'b0;
                    end else begin
                        // Frame boundary is the only point where live inputs are taken.
                        load      = 1'b1;
                        period_d  = period;
                        oneshot_d = oneshot;
                    end
                end else begin
                    count_d = cnt_inc[CW-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            period_q     <= '0;
            oneshot_q    <= 1'b0;
            stop_pend_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            period_q     <= period_d;
            oneshot_q    <= oneshot_d;
            stop_pend_q  <= stop_pend_d;
            frame_done_q <= frame_done_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        rlbp_phase_chan #(.CW(CW)) u_chan (
            .clk     (clk),
            .reset   (reset),
            .load    (load),
            .run     (state_q == RUN),
            .cnt     (count_q),
            .rise_in (t_rise[i*CW +: CW]),
            .fall_in (t_fall[i*CW +: CW]),
            .pol_in  (polarity[i]),
            .en_in   (chan_en[i]),
            .out     (out[i])
        );
    end

    assign count      = count_q;
    assign busy       = (state_q == RUN);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_rlbp_phase_gen.sv
// tb/tb_rlbp_phase_gen.sv - scoreboard bench for rlbp_phase_gen (default build)
module tb_rlbp_phase_gen;

    localparam int NCH = 7;
    localparam int CW  = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              stop;
    logic              oneshot;
    logic [CW-1:0]     period;
    logic [NCH*CW-1:0] t_rise;
    logic [NCH*CW-1:0] t_fall;
    logic [NCH-1:0]    polarity;
    logic [NCH-1:0]    chan_en;
    logic [NCH-1:0]    out;
    logic [CW-1:0]     count;
    logic              busy;
    logic              frame_done;

    always #5 clk = ~clk;

    rlbp_phase_gen #(.NCH(NCH), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .oneshot    (oneshot),
        .period     (period),
        .t_rise     (t_rise),
        .t_fall     (t_fall),
        .polarity   (polarity),
        .chan_en    (chan_en),
        .out        (out),
        .count      (count),
        .busy       (busy),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [CW-1:0]  cnt;
        logic           busy;
        logic           fd;
        logic [NCH-1:0] out;
    } exp_t;

    exp_t           q[$];
    int             total  = 0;
    int             passed = 0;
    int             cyc    = 0;

    int             x_rise[NCH];
    int             x_fall[NCH];
    logic [NCH-1:0] x_pol;
    logic [NCH-1:0] x_en;
    int             x_per;
    logic [NCH-1:0] carry_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    function automatic logic [NCH-1:0] fexp(input int c);
        logic [NCH-1:0] r;
        bit a;
        for (int i = 0; i < NCH; i++) begin
            if (x_rise[i] < x_fall[i])      a = (c >= x_rise[i]) && (c < x_fall[i]);
            else if (x_rise[i] > x_fall[i]) a = (c >= x_rise[i]) || (c < x_fall[i]);
            else                            a = 1'b0;
            r[i] = (a & x_en[i]) ^ x_pol[i];
        end
        return r;
    endfunction

    task automatic apply_cfg();
        for (int i = 0; i < NCH; i++) begin
            t_rise[i*CW +: CW] = x_rise[i][CW-1:0];
            t_fall[i*CW +: CW] = x_fall[i][CW-1:0];
        end
        polarity = x_pol;
        chan_en  = x_en;
        period   = x_per[CW-1:0];
    endtask

    task automatic push_frame(input bit first, input bit to_idle, input int nk);
        exp_t e;
        for (int k = 0; k < nk; k++) begin
            e.cnt  = k[CW-1:0];
            e.busy = 1'b1;
            e.fd   = (k == 0) && !first;
            e.out  = (k == 0) ? (first ? polarity : carry_out) : fexp(k - 1);
            q.push_back(e);
        end
        carry_out = fexp(x_per - 1);
        if (to_idle) begin
            e.cnt  = '0;
            e.busy = 1'b0;
            e.fd   = 1'b1;
            e.out  = carry_out;
            q.push_back(e);
        end
    endtask

    task automatic push_idle(input int n);
        exp_t e;
        e.cnt  = '0;
        e.busy = 1'b0;
        e.fd   = 1'b0;
        e.out  = polarity;
        for (int k = 0; k < n; k++) q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (q.size() == 0) begin
            chk("queue_underflow", 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            chk("out",        32'(out),        32'(e.out));
            chk("count",      32'(count),      32'(e.cnt));
            chk("busy",       32'(busy),       32'(e.busy));
            chk("frame_done", 32'(frame_done), 32'(e.fd));
        end
    endtask

    task automatic drain();
        while (q.size() > 0) step();
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        oneshot = 1'b1;
        x_rise  = '{5, 15, 7, 2, 2, 18, 0};
        x_fall  = '{10, 3, 7, 12, 25, 1, 20};
        x_pol   = 7'b0000101;
        x_en    = 7'b1110111;
        x_per   = 20;
        carry_out = '0;
        apply_cfg();

        // reset held three cycles
        push_idle(3);
        repeat (3) step();
        reset = 1'b0;
        push_idle(2);
        drain();

        // one-shot frame: normal, wrap, degenerate and disabled channels
        x_pol = 7'b0000100;
        apply_cfg();
        push_idle(1);
        drain();
        push_frame(1'b1, 1'b1, 20);
        push_idle(2);
        start = 1'b1;
        step();
        start = 1'b0;
        drain();

        // shadowing: rise change mid-frame only lands in the next frame
        x_per = 16; x_rise[0] = 4; x_fall[0] = 10;
        oneshot = 1'b0;
        apply_cfg();
        push_frame(1'b1, 1'b0, 16);
        x_rise[0] = 8;
        push_frame(1'b0, 1'b1, 16);
        push_idle(2);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        apply_cfg();
        repeat (10) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        drain();

        // stop early in a continuous period-10 frame
        x_per = 10;
        apply_cfg();
        push_frame(1'b1, 1'b1, 10);
        push_idle(2);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        drain();

        // start and stop together in IDLE
        push_idle(3);
        start = 1'b1;
        stop  = 1'b1;
        drain();
        start = 1'b0;
        stop  = 1'b0;
        push_idle(1);
        drain();

        // reset at count 5, then live polarity tracking in IDLE
        push_frame(1'b1, 1'b0, 6);
        push_idle(1);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        polarity = 7'b1110000;
        push_idle(2);
        drain();

        // period 0 means a full 2^CW frame
        x_per = 4096; x_pol = 7'b0000000;
        x_rise[0] = 4000; x_fall[0] = 100;
        x_rise[1] = 4095; x_fall[1] = 0;
        oneshot = 1'b1;
        apply_cfg();
        push_idle(1);
        drain();
        push_frame(1'b1, 1'b1, 4096);
        push_idle(2);
        start = 1'b1;
        step();
        start = 1'b0;
        drain();

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
